// File: rtl/seg7_capture_if.sv
// Bundles the tapped display bus and the frame handshake of seg7_capture.
// The master side drives the display lines and the ack; the slave side is the capture block.
interface seg7_capture_if #(
  parameter int NDIG = 4
);
  logic [6:0]        seg;
  logic [NDIG-1:0]   an;
  logic [4*NDIG-1:0] frame_digits;
  logic              frame_valid;
  logic              frame_ack;
  logic [NDIG-1:0]   pos_mask;
  logic              bad_pattern;
  logic              overrun;

  modport master (
    output seg, an, frame_ack,
    input  frame_digits, frame_valid, pos_mask, bad_pattern, overrun
  );

  modport slave (
    input  seg, an, frame_ack,
    output frame_digits, frame_valid, pos_mask, bad_pattern, overrun
  );
endinterface

// File: rtl/seg7_capture.sv
// Recovers digit codes from a multiplexed active-low 7-segment bus, debounces
// the digit switching and hands complete frames to a consumer via valid/ack.
module seg7_capture #(
  parameter int NDIG   = 4,
  parameter int STABLE = 4
) (
  input  logic         clk,
  input  logic         reset,
  seg7_capture_if.slave bus
);
  // One bit wider than the nominal 8 so STABLE=255 can still saturate at 256.
  localparam int              CW         = 9;
  localparam logic [CW-1:0]   CNT_STABLE = CW'(STABLE);
  localparam logic [CW-1:0]   CNT_SAT    = CW'(STABLE + 1);

  logic [6:0]            seg_q;
  logic [NDIG-1:0]       an_q;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [NDIG-1:0][3:0]  work_q, work_d;
  logic [NDIG-1:0]       mask_q, mask_d;
  logic [4*NDIG-1:0]     frame_q, frame_d;
  logic                  valid_q, valid_d;
  logic                  bad_q, bad_d;
  logic                  ovr_q, ovr_d;

  logic                  accept;
  logic                  complete;
  logic [NDIG-1:0]       sel;
  logic [3:0]            code;

  function automatic logic [3:0] decode(input logic [6:0] s);
    case (s)
      7'b1000000: return 4'd0;
      7'b1111001: return 4'd1;
      7'b0100100: return 4'd2;
      7'b0110000: return 4'd3;
      7'b0011001: return 4'd4;
      7'b0010010: return 4'd5;
      7'b0000010: return 4'd6;
      7'b1111000: return 4'd7;
      7'b0000000: return 4'd8;
      7'b0010000: return 4'd9;
      7'b1111111: return 4'd10;
      7'b0111111: return 4'd11;
      default:    return 4'hF;
    endcase
  endfunction

  // A stable run hits CNT_STABLE exactly once, so each run accepts at most once.
  assign sel    = ~an_q;
  assign accept = (cnt_q == CNT_STABLE) && $onehot(sel);
  assign code   = decode(seg_q);

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    cnt_d    = cnt_q;
    work_d   = work_q;
    mask_d   = mask_q;
    frame_d  = frame_q;
    valid_d  = valid_q;
    bad_d    = 1'b0;
    ovr_d    = 1'b0;
    complete = 1'b0;

    if ({bus.an, bus.seg} == {an_q, seg_q}) begin
      if (cnt_q < CNT_SAT) cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = CW'(1);
    end

    if (accept) begin
      for (int i = 0; i < NDIG; i++) begin
        if (sel[i]) work_d[i] = code;
      end
      mask_d = mask_q | sel;
      bad_d  = (code == 4'hF);
      if (&mask_d) begin
        complete = 1'b1;
        mask_d   = '0;
        if (!valid_q || bus.frame_ack) begin
          frame_d = work_d;
          valid_d = 1'b1;
        end else begin
          ovr_d = 1'b1;
        end
      end
    end

    // A completion in the same cycle as the ack replaces the frame instead of dropping valid.
    if (!complete && valid_q && bus.frame_ack) valid_d = 1'b0;
  end

  // NOTE: state registers use non-blocking assignments so all of them update together on the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_q   <= 7'h7F;
      an_q    <= '1;
      cnt_q   <= '0;
      work_q  <= '0;
      mask_q  <= '0;
      frame_q <= '0;
      valid_q <= 1'b0;
      bad_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      seg_q   <= bus.seg;
      an_q    <= bus.an;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      mask_q  <= mask_d;
      frame_q <= frame_d;
      valid_q <= valid_d;
      bad_q   <= bad_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.frame_digits = frame_q;
  assign bus.frame_valid  = valid_q;
  assign bus.pos_mask     = mask_q;
  assign bus.bad_pattern  = bad_q;
  assign bus.overrun      = ovr_q;
endmodule

// File: tb/tb_seg7_capture.sv
// Drives directed and random display-bus traffic into seg7_capture and compares every
// output each cycle with a sample-history reference model.
module tb_seg7_capture;
  localparam int NDIG   = 4;
  localparam int STABLE = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seg7_capture_if #(.NDIG(NDIG)) bus ();

  seg7_capture #(.NDIG(NDIG), .STABLE(STABLE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [6:0] seg_tab [12] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b1111111, 7'b0111111};

  typedef struct {
    logic [6:0]      seg;
    logic [NDIG-1:0] an;
  } sample_t;

  sample_t           hist [$];
  logic [3:0]        m_work [NDIG];
  logic [NDIG-1:0]   m_mask;
  logic [4*NDIG-1:0] m_frame;
  logic              m_valid, m_bad, m_ovr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Length of the trailing run of identical samples seen since reset.
  function automatic int run_len();
    int n = 0;
    for (int k = hist.size() - 1; k >= 0; k--) begin
      if (hist[k].seg == hist[hist.size()-1].seg && hist[k].an == hist[hist.size()-1].an) n++;
      else break;
    end
    return n;
  endfunction

  function automatic logic [3:0] ref_decode(input logic [6:0] s);
    for (int k = 0; k < 12; k++) if (seg_tab[k] == s) return 4'(k);
    return 4'hF;
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < NDIG; i++) m_work[i] = 4'd0;
    m_mask = '0; m_frame = '0; m_valid = 1'b0; m_bad = 1'b0; m_ovr = 1'b0;
  endtask

  task automatic model_edge(input logic [6:0] s, input logic [NDIG-1:0] a, input logic ack);
    bit acc, done;
    int pos;
    logic [3:0] c;
    sample_t smp;
    done  = 0;
    m_bad = 1'b0;
    m_ovr = 1'b0;
    acc = hist.size() > 0 && run_len() == STABLE && $countones(~hist[hist.size()-1].an) == 1;
    if (acc) begin
      pos = 0;
      for (int i = 0; i < NDIG; i++) if (!hist[hist.size()-1].an[i]) pos = i;
      c = ref_decode(hist[hist.size()-1].seg);
      m_work[pos] = c;
      m_mask[pos] = 1'b1;
      m_bad = (c == 4'hF);
      if (&m_mask) begin
        done   = 1;
        m_mask = '0;
        if (!m_valid || ack) begin
          for (int i = 0; i < NDIG; i++) m_frame[4*i +: 4] = m_work[i];
          m_valid = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end
    end
    if (!done && m_valid && ack) m_valid = 1'b0;
    smp.seg = s;
    smp.an  = a;
    hist.push_back(smp);
    if (hist.size() > STABLE + 2) void'(hist.pop_front());
  endtask

  task automatic drive(input logic [6:0] s, input logic [NDIG-1:0] a, input logic ack);
    bus.seg       = s;
    bus.an        = a;
    bus.frame_ack = ack;
    @(posedge clk);
    if (reset) model_reset();
    else model_edge(s, a, ack);
    #1;
    check("frame_digits", 32'(bus.frame_digits), 32'(m_frame));
    check("frame_valid",  32'(bus.frame_valid),  32'(m_valid));
    check("pos_mask",     32'(bus.pos_mask),     32'(m_mask));
    check("bad_pattern",  32'(bus.bad_pattern),  32'(m_bad));
    check("overrun",      32'(bus.overrun),      32'(m_ovr));
  endtask

  task automatic hold(input logic [6:0] s, input logic [NDIG-1:0] a, input int n, input logic ack);
    repeat (n) drive(s, a, ack);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) drive(7'($urandom), 4'($urandom), 1'($urandom));
    reset = 1'b0;
  endtask

  // Four positions, each held 6 cycles; ack only on the cycle that completes the frame.
  task automatic frame(input int d0, input int d1, input int d2, input int d3, input logic ack_last);
    hold(seg_tab[d0], 4'b1110, 6, 1'b0);
    hold(seg_tab[d1], 4'b1101, 6, 1'b0);
    hold(seg_tab[d2], 4'b1011, 6, 1'b0);
    for (int i = 0; i < 6; i++) drive(seg_tab[d3], 4'b0111, (i == STABLE) ? ack_last : 1'b0);
  endtask

  initial begin
    logic [NDIG-1:0] a;
    logic [6:0]      s;
    int              len;

    do_reset();
    check("reset_valid", 32'(bus.frame_valid), 32'd0);
    check("reset_mask",  32'(bus.pos_mask),    32'd0);

    frame(1, 2, 3, 11, 1'b0);
    check("basic_digits", 32'(bus.frame_digits), 32'h0000B321);
    check("basic_valid",  32'(bus.frame_valid),  32'd1);
    drive(seg_tab[11], 4'b0111, 1'b1);
    check("ack_drop", 32'(bus.frame_valid), 32'd0);

    hold(seg_tab[8], 4'b1110, 3, 1'b0);
    hold(seg_tab[5], 4'b1110, 4, 1'b0);
    hold(seg_tab[10], 4'b1111, 2, 1'b0);
    check("glitch_mask", 32'(bus.pos_mask), 32'h1);

    hold(7'b1010101, 4'b1011, 5, 1'b0);
    check("bad_pulse", 32'(bus.bad_pattern), 32'd1);
    check("bad_mask",  32'(bus.pos_mask),    32'h5);

    hold(seg_tab[3], 4'b1100, 10, 1'b0);
    hold(seg_tab[3], 4'b1111, 10, 1'b0);
    check("inv_anode_mask", 32'(bus.pos_mask), 32'h5);

    frame(4, 5, 6, 7, 1'b0);
    check("ovr_first", 32'(bus.frame_digits), 32'h00007654);
    frame(9, 8, 0, 1, 1'b0);
    check("ovr_keep", 32'(bus.frame_digits), 32'h00007654);
    frame(2, 3, 10, 11, 1'b1);
    check("ack_reload_digits", 32'(bus.frame_digits), 32'h0000BA32);
    check("ack_reload_valid",  32'(bus.frame_valid),  32'd1);

    for (int k = 0; k < 300; k++) begin
      if (k == 150) do_reset();
      case ($urandom_range(0, 9))
        8:       a = 4'b1111;
        9:       a = 4'($urandom);
        default: a = ~(4'b0001 << $urandom_range(0, NDIG - 1));
      endcase
      s   = ($urandom_range(0, 7) == 0) ? 7'($urandom) : seg_tab[$urandom_range(0, 11)];
      len = $urandom_range(1, STABLE + 3);
      repeat (len) drive(s, a, ($urandom_range(0, 3) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
